alu_arbiter: RTL and testbench

Shares one 64-bit combinational `alu` instance among `NREQ` requesters in the sequential core, e.g. main execute, PC/branch-target compute and address generation. Each request carries a 32-bit instruction word, which selects the ALU op through funct3/funct7, plus two 64-bit operands. The block grants one requester, registers its operands, and returns a registered result under a valid/ready handshake. It is a 3-state sequencer around the existing ALU; it does not decode opcodes.

---
 rtl/alu_arb_pkg.sv | 24 ++
 rtl/alu.sv | 43 ++++
 rtl/alu_arb_pick.sv | 34 +++
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM state encoding,
// requester limit and the funct3/funct7 values the ALU decodes.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int NREQ_MAX = 4;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [6:0] FUNCT7_ALT = 7'h20;

endpackage

// File: rtl/alu.sv
// Existing 64-bit combinational ALU: op chosen by funct3, with funct7 bit 5
// selecting SUB/SRA. Shift amount is the low six bits of in2.
module alu
  import alu_arb_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  output logic [63:0] out
);

  logic [2:0] funct3;
  logic       alt;
  logic [5:0] shamt;

  assign funct3 = instr[14:12];
  assign alt    = (instr[31:25] == FUNCT7_ALT);
  assign shamt  = in2[5:0];

  // Operation select
  always_comb begin
    out = 64'd0;
    case (funct3)
      F3_ADD: begin
        if (alt) out = in1 - in2;
        else     out = in1 + in2;
      end
      F3_SLL:  out = in1 << shamt;
      F3_SLT:  out = {63'd0, ($signed(in1) < $signed(in2))};
      F3_SLTU: out = {63'd0, (in1 < in2)};
      F3_XOR:  out = in1 ^ in2;
      F3_SR: begin
        // Kept as separate branches so the arithmetic shift stays signed.
        if (alt) out = $unsigned($signed(in1) >>> shamt);
        else     out = in1 >> shamt;
      end
      F3_OR:   out = in1 | in2;
      F3_AND:  out = in1 & in2;
      default: out = 64'd0;
    endcase
  end

endmodule

// File: rtl/alu_arb_pick.sv
// Masked priority picker: scans the valid vector starting at 'start',
// wrapping modulo NREQ, and returns the first hit as one-hot and index.
module alu_arb_pick #(
  parameter int NREQ = 2,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [GW-1:0]   start,
  output logic [NREQ-1:0] grant,
  output logic [GW-1:0]   idx,
  output logic            any
);

  // Wrapped scan; first valid position from the pointer wins
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      logic [GW:0] pos;
      pos = {1'b0, start} + (GW+1)'(k);
      if (pos >= (GW+1)'(NREQ)) pos = pos - (GW+1)'(NREQ);
      else                      pos = pos;
      if (!any && valid[pos[GW-1:0]]) begin
        any                 = 1'b1;
        grant[pos[GW-1:0]]  = 1'b1;
        idx                 = pos[GW-1:0];
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters with an IDLE/EXEC/RESP sequencer.
// Define ALU_ARB_RR_EN for round-robin; otherwise lowest index has priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int  NREQ = 2,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_instr,
  input  logic [64*NREQ-1:0] req_in1,
  input  logic [64*NREQ-1:0] req_in2,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [63:0]       rsp_data,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t            state_r, state_nx;
  logic [31:0]       op_instr_r;
  logic [63:0]       op_in1_r, op_in2_r;
  logic [GW-1:0]     grant_r;
  logic [NREQ-1:0]   rsp_valid_r;
  logic [63:0]       rsp_data_r;
  logic              busy_r;

  logic [NREQ-1:0]   pick_grant_s;
  logic [GW-1:0]     pick_idx_s;
  logic              pick_any_s;
  logic [GW-1:0]     pick_start_s;
  logic [31:0]       sel_instr_s;
  logic [63:0]       sel_in1_s, sel_in2_s;
  logic [63:0]       alu_out_s;
  logic              handshake_s;

  alu_arb_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
    .valid (req_valid),
    .start (pick_start_s),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  alu u_alu (
    .instr (op_instr_r),
    .in1   (op_in1_r),
    .in2   (op_in2_r),
    .out   (alu_out_s)
  );

  assign handshake_s = (state_r == ST_RESP) && rsp_ready[grant_r];

`ifdef ALU_ARB_RR_EN
  logic [GW-1:0] ptr_r;

  // Round-robin pointer moves past the requester just served
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (handshake_s) begin
      if (grant_r == GW'(NREQ-1)) ptr_r <= '0;
      else                        ptr_r <= grant_r + GW'(1'b1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign pick_start_s = ptr_r;
`else
  assign pick_start_s = '0;
`endif

  // One-hot AND-OR mux of the winning requester's fields
  always_comb begin
    sel_instr_s = 32'd0;
    sel_in1_s   = 64'd0;
    sel_in2_s   = 64'd0;
    for (int i = 0; i < NREQ; i++) begin
      sel_instr_s = sel_instr_s | ({32{pick_grant_s[i]}} & req_instr[32*i +: 32]);
      sel_in1_s   = sel_in1_s   | ({64{pick_grant_s[i]}} & req_in1[64*i +: 64]);
      sel_in2_s   = sel_in2_s   | ({64{pick_grant_s[i]}} & req_in2[64*i +: 64]);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nx;
  end

  // Next state and combinational accept
  always_comb begin
    state_nx  = state_r;
    req_ready = '0;
    case (state_r)
      ST_IDLE: begin
        if (!reset) req_ready = pick_grant_s;
        else        req_ready = '0;
        if (pick_any_s) state_nx = ST_EXEC;
        else            state_nx = ST_IDLE;
      end
      ST_EXEC: state_nx = ST_RESP;
      ST_RESP: begin
        if (handshake_s) state_nx = ST_IDLE;
        else             state_nx = ST_RESP;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand capture, result register and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      op_instr_r  <= 32'd0;
      op_in1_r    <= 64'd0;
      op_in2_r    <= 64'd0;
      grant_r     <= '0;
      rsp_valid_r <= '0;
      rsp_data_r  <= 64'd0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            op_instr_r <= sel_instr_s;
            op_in1_r   <= sel_in1_s;
            op_in2_r   <= sel_in2_s;
            grant_r    <= pick_idx_s;
            busy_r     <= 1'b1;
          end
        end
        ST_EXEC: begin
          rsp_data_r  <= alu_out_s;
          rsp_valid_r <= ONE_HOT0 << grant_r;
        end
        ST_RESP: begin
          if (handshake_s) begin
            rsp_valid_r <= '0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          rsp_valid_r <= '0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = busy_r;
  assign grant_id  = grant_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares on each response handshake.
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int GW   = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_instr;
  logic [64*NREQ-1:0] req_in1;
  logic [64*NREQ-1:0] req_in2;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [63:0]       rsp_data;
  logic              busy;
  logic [GW-1:0]     grant_id;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_instr (req_instr),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timed_out(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL timeout_%s at %0t", name, $time);
  endtask

  // Monitor: one pop per handshake seen just before the completing edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && ((rsp_valid & rsp_ready) != '0)) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_valid", 64'(rsp_valid), 64'd1 << e.id);
          check("rsp_data", rsp_data, e.data);
          check("grant_id", 64'(grant_id), 64'(e.id));
        end
      end
    end
  end

  task automatic drive(input int id, input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
    req_instr[32*id +: 32] = ins;
    req_in1[64*id +: 64]   = a;
    req_in2[64*id +: 64]   = b;
    req_valid[id]          = 1'b1;
  endtask

  task automatic wait_ready(input int id, output bit got);
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
  endtask

  // Single request: accept, scramble operands afterwards, check 2-cycle latency
  task automatic issue(input int id, input logic [31:0] ins, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp);
    bit got;
    @(posedge clk); #1;
    drive(id, ins, a, b);
    wait_ready(id, got);
    if (!got) begin
      timed_out("accept");
      req_valid[id] = 1'b0;
      return;
    end
    check("req_ready_onehot", 64'(req_ready), 64'd1 << id);
    sb.push_back('{id: 2'(id), data: exp});
    @(posedge clk); #1;
    req_valid[id]        = 1'b0;
    req_in1[64*id +: 64] = ~a;
    req_in2[64*id +: 64] = ~b;
    @(negedge clk);
    check("exec_no_rsp", 64'(rsp_valid), 64'd0);
    check("exec_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_rsp_valid", 64'(rsp_valid), 64'd1 << id);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) timed_out(name);
  endtask

  initial begin
    bit got;
    reset     = 1'b1;
    req_valid = '0;
    req_instr = '0;
    req_in1   = '0;
    req_in2   = '0;
    rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;

    issue(0, 32'h0000_0033, 64'd5, 64'd7, 64'd12);
    issue(1, 32'h4000_0033, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(1, 32'h4000_5033, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
    drain("basic");

    // Response stall; the non-granted rsp_ready bit is high and must be ignored
    rsp_ready = 2'b10;
    issue(0, 32'h0000_0033, 64'd1, 64'd2, 64'd3);
    @(posedge clk); #1;
    drive(1, 32'h0000_0033, 64'd10, 64'd20);
    sb.push_back('{id: 2'd1, data: 64'd30});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_data", rsp_data, 64'd3);
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    wait_ready(1, got);
    if (!got) timed_out("hold_accept");
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain("hold");

    // Both requesters continuously valid
    @(posedge clk); #1;
    drive(0, 32'h0000_4033, 64'hF0, 64'hFF);
    drive(1, 32'h0000_3033, 64'd1, 64'd2);
`ifdef ALU_ARB_RR_EN
    sb.push_back('{id: 2'd0, data: 64'h0F});
    sb.push_back('{id: 2'd1, data: 64'd1});
    sb.push_back('{id: 2'd0, data: 64'h0F});
    sb.push_back('{id: 2'd1, data: 64'd1});
`else
    sb.push_back('{id: 2'd0, data: 64'h0F});
    sb.push_back('{id: 2'd0, data: 64'h0F});
    sb.push_back('{id: 2'd0, data: 64'h0F});
    sb.push_back('{id: 2'd0, data: 64'h0F});
`endif
    drain("contend");
    #1;
    req_valid = '0;
    repeat (2) @(posedge clk);

    // Reset while an op is in EXEC; the op is discarded and re-issued
    #1;
    drive(0, 32'h0000_0033, 64'd5, 64'd7);
    wait_ready(0, got);
    if (!got) timed_out("rst_accept");
    @(posedge clk); #1;
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_data", rsp_data, 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_grant_id", 64'(grant_id), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    sb.push_back('{id: 2'd0, data: 64'd12});
    reset = 1'b0;
    @(negedge clk);
    check("rearb_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("rearb_exec", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("rearb_rsp_valid", 64'(rsp_valid), 64'd1);
    drain("rearb");

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
